// File: rtl/race_timer_pkg.sv
// race_timer_pkg: shared types, default time constants and the lap
// validity rule used by every race_timer timing channel.
package race_timer_pkg;

  // Per-channel lap-timing state.
  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_COUNT    = 2'd1,
    CH_FINISHED = 2'd2
  } chan_state_t;

  // Defaults for a 65 MHz pclk and 0.01 s time units.
  localparam int unsigned DEF_TICK_DIV     = 650000;
  localparam int unsigned DEF_MAX_LAP_TIME = 4000;
  localparam int unsigned DEF_MIN_LAP_TIME = 100;

  // A lap counts only if every checkpoint was seen, the lap did not time
  // out, and it lasted strictly longer than the minimum. Callers pass
  // zero-extended TIME_W values (TIME_W <= 32).
  function automatic logic lap_valid(input logic        cp_seen,
                                     input logic        timed_out,
                                     input logic [31:0] cur_time,
                                     input logic [31:0] min_time);
    return cp_seen && !timed_out && (cur_time > min_time);
  endfunction

endpackage

// File: rtl/race_timer_channel.sv
// lap_timer_channel: one player's lap timer.
//   pclk, rst           clock and synchronous active-high reset (includes clear)
//   start, stop         shared run/pause levels
//   tick                one-cycle 0.01 s time-unit strobe from the prescaler
//   lap_finished        finish-line pulse for this player
//   checkpoints_passed  all checkpoints of the current lap seen
//   current/last/best   lap times (best = 0 means no valid lap yet)
//   lap_count           valid laps completed
//   max_time_exceeded   current lap saturated at MAX_LAP_TIME
//   finished            player reached LAPS_TO_WIN valid laps
//   counting            channel is in COUNT (enables the shared prescaler)
module lap_timer_channel
  import race_timer_pkg::*;
#(
  parameter int unsigned TIME_W       = 16,
  parameter int unsigned MAX_LAP_TIME = DEF_MAX_LAP_TIME,
  parameter int unsigned MIN_LAP_TIME = DEF_MIN_LAP_TIME,
  parameter int unsigned LAPS_TO_WIN  = 3,
  parameter int unsigned LAP_CNT_W    = 4
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 tick,
  input  logic                 lap_finished,
  input  logic                 checkpoints_passed,
  output logic [TIME_W-1:0]    current,
  output logic [TIME_W-1:0]    last,
  output logic [TIME_W-1:0]    best,
  output logic [LAP_CNT_W-1:0] lap_count,
  output logic                 max_time_exceeded,
  output logic                 finished,
  output logic                 counting
);

  localparam logic [TIME_W-1:0]    MAX_T    = TIME_W'(MAX_LAP_TIME);
  localparam logic [TIME_W-1:0]    MIN_T    = TIME_W'(MIN_LAP_TIME);
  localparam logic [LAP_CNT_W-1:0] LAST_LAP = LAP_CNT_W'(LAPS_TO_WIN - 1);

  chan_state_t state;

  assign counting = (state == CH_COUNT);

  // Priority inside COUNT: stop, then lap event, then tick. A lap event
  // swallows a coincident tick so the new lap starts at exactly 0.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state             <= CH_IDLE;
      current           <= '0;
      last              <= '0;
      best              <= '0;
      lap_count         <= '0;
      max_time_exceeded <= 1'b0;
      finished          <= 1'b0;
    end else begin
      unique case (state)
        CH_IDLE: begin
          if (start && !stop) state <= CH_COUNT;
        end
        CH_COUNT: begin
          if (stop) begin
            state <= CH_IDLE;
          end else if (lap_finished) begin
            if (lap_valid(checkpoints_passed, max_time_exceeded,
                          32'(current), 32'(MIN_T))) begin
              last <= current;
              if (best == '0 || current < best) best <= current;
              lap_count <= lap_count + 1'b1;
              if (lap_count == LAST_LAP) begin
                state    <= CH_FINISHED;
                finished <= 1'b1;
              end
            end
            current           <= '0;
            max_time_exceeded <= 1'b0;
          end else if (tick) begin
            if (current < MAX_T) begin
              current <= current + 1'b1;
            end else begin
              current           <= MAX_T;
              max_time_exceeded <= 1'b1;
            end
          end
        end
        CH_FINISHED: begin
          state <= CH_FINISHED;
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/race_timer.sv
// race_timer: multi-player lap timer with a shared 0.01 s prescaler,
// winner arbitration and race completion.
//   pclk, rst           clock, synchronous active-high reset
//   start, stop         run / pause levels; clear restarts the race
//   lap_finished        per-player finish-line pulses
//   checkpoints_passed  per-player all-checkpoints-seen levels
//   current/last/best_lap_time  packed per player, player 0 in LSBs
//   lap_count, max_time_exceeded, player_finished  per-player status
//   winner_valid, winner_id      sticky first finisher (lowest index on ties)
//   race_done           every player finished
module race_timer
  import race_timer_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned TIME_W       = 16,
  parameter int unsigned MAX_LAP_TIME = DEF_MAX_LAP_TIME,
  parameter int unsigned MIN_LAP_TIME = DEF_MIN_LAP_TIME,
  parameter int unsigned LAPS_TO_WIN  = 3,
  parameter int unsigned LAP_CNT_W    = 4,
  parameter int unsigned ID_W         = 3
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             clear,
  input  logic [NUM_PLAYERS-1:0]           lap_finished,
  input  logic [NUM_PLAYERS-1:0]           checkpoints_passed,
  output logic [NUM_PLAYERS*TIME_W-1:0]    current_lap_time,
  output logic [NUM_PLAYERS*TIME_W-1:0]    last_lap_time,
  output logic [NUM_PLAYERS*TIME_W-1:0]    best_lap_time,
  output logic [NUM_PLAYERS*LAP_CNT_W-1:0] lap_count,
  output logic [NUM_PLAYERS-1:0]           max_time_exceeded,
  output logic [NUM_PLAYERS-1:0]           player_finished,
  output logic                             winner_valid,
  output logic [ID_W-1:0]                  winner_id,
  output logic                             race_done
);

  localparam int unsigned PRE_W = $clog2(TICK_DIV);

  logic                   rst_i;
  logic [PRE_W-1:0]       pre_cnt;
  logic                   tick;
  logic [NUM_PLAYERS-1:0] counting;
  logic                   any_count;
  logic                   first_found;
  logic [ID_W-1:0]        first_id;

  assign rst_i     = rst | clear;
  assign any_count = |counting;
  assign tick      = any_count && (pre_cnt == PRE_W'(TICK_DIV - 1));

  // Prescaler freezes while nobody counts so a pause keeps sub-unit phase.
  always_ff @(posedge pclk) begin
    if (rst_i) begin
      pre_cnt <= '0;
    end else if (any_count) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PLAYERS; g++) begin : g_chan
      lap_timer_channel #(
        .TIME_W      (TIME_W),
        .MAX_LAP_TIME(MAX_LAP_TIME),
        .MIN_LAP_TIME(MIN_LAP_TIME),
        .LAPS_TO_WIN (LAPS_TO_WIN),
        .LAP_CNT_W   (LAP_CNT_W)
      ) u_chan (
        .pclk              (pclk),
        .rst               (rst_i),
        .start             (start),
        .stop              (stop),
        .tick              (tick),
        .lap_finished      (lap_finished[g]),
        .checkpoints_passed(checkpoints_passed[g]),
        .current           (current_lap_time[g*TIME_W +: TIME_W]),
        .last              (last_lap_time[g*TIME_W +: TIME_W]),
        .best              (best_lap_time[g*TIME_W +: TIME_W]),
        .lap_count         (lap_count[g*LAP_CNT_W +: LAP_CNT_W]),
        .max_time_exceeded (max_time_exceeded[g]),
        .finished          (player_finished[g]),
        .counting          (counting[g])
      );
    end
  endgenerate

  // Lowest-index finisher wins simultaneous finishes.
  always_comb begin
    first_found = 1'b0;
    first_id    = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (!first_found && player_finished[i]) begin
        first_found = 1'b1;
        first_id    = ID_W'(i);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst_i) begin
      winner_valid <= 1'b0;
      winner_id    <= '0;
      race_done    <= 1'b0;
    end else begin
      race_done <= &player_finished;
      if (!winner_valid && first_found) begin
        winner_valid <= 1'b1;
        winner_id    <= first_id;
      end
    end
  end

endmodule

// File: tb/tb_race_timer.sv
// Bench for race_timer: a per-player behavioural model is stepped on every
// clock edge and compared against all outputs on the falling edge, with
// hand-computed literal pins placed along a directed stimulus sequence.
module tb_race_timer;

  localparam int NP   = 2;
  localparam int TD   = 4;
  localparam int TW   = 16;
  localparam int MAXT = 20;
  localparam int MINT = 3;
  localparam int LTW  = 2;
  localparam int LCW  = 4;
  localparam int IDW  = 3;

  logic              pclk;
  logic              rst, start, stop, clear;
  logic [NP-1:0]     lap, cp;
  logic [NP*TW-1:0]  cur_o, last_o, best_o;
  logic [NP*LCW-1:0] cnt_o;
  logic [NP-1:0]     exc_o, fin_o;
  logic              wv_o, rd_o;
  logic [IDW-1:0]    wid_o;

  race_timer #(
    .NUM_PLAYERS (NP),
    .TICK_DIV    (TD),
    .TIME_W      (TW),
    .MAX_LAP_TIME(MAXT),
    .MIN_LAP_TIME(MINT),
    .LAPS_TO_WIN (LTW),
    .LAP_CNT_W   (LCW),
    .ID_W        (IDW)
  ) dut (
    .pclk              (pclk),
    .rst               (rst),
    .start             (start),
    .stop              (stop),
    .clear             (clear),
    .lap_finished      (lap),
    .checkpoints_passed(cp),
    .current_lap_time  (cur_o),
    .last_lap_time     (last_o),
    .best_lap_time     (best_o),
    .lap_count         (cnt_o),
    .max_time_exceeded (exc_o),
    .player_finished   (fin_o),
    .winner_valid      (wv_o),
    .winner_id         (wid_o),
    .race_done         (rd_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int p, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, p, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit m_run [NP];
  bit m_done[NP];
  bit m_exc [NP];
  int m_cur [NP];
  int m_last[NP];
  int m_best[NP];
  int m_cnt [NP];
  int m_phase;
  bit m_wv;
  int m_wid;
  bit m_rd;

  always @(posedge pclk) begin : model
    bit any_run, tk, all_done;
    if (rst || clear) begin
      for (int i = 0; i < NP; i++) begin
        m_run[i] = 0; m_done[i] = 0; m_exc[i] = 0;
        m_cur[i] = 0; m_last[i] = 0; m_best[i] = 0; m_cnt[i] = 0;
      end
      m_phase = 0; m_wv = 0; m_wid = 0; m_rd = 0;
    end else begin
      // winner and race_done follow the finish flags one cycle later
      all_done = 1;
      for (int i = 0; i < NP; i++) if (!m_done[i]) all_done = 0;
      m_rd = all_done;
      if (!m_wv) begin
        for (int i = NP - 1; i >= 0; i--) if (m_done[i]) begin m_wv = 1; m_wid = i; end
      end
      any_run = 0;
      for (int i = 0; i < NP; i++) if (m_run[i]) any_run = 1;
      tk = any_run && (m_phase == TD - 1);
      if (any_run) m_phase = (m_phase + 1) % TD;
      for (int i = 0; i < NP; i++) begin
        if (m_done[i]) continue;
        if (!m_run[i]) begin
          if (start && !stop) m_run[i] = 1;
          continue;
        end
        if (stop) begin m_run[i] = 0; continue; end
        if (lap[i]) begin
          if (cp[i] && !m_exc[i] && m_cur[i] > MINT) begin
            m_last[i] = m_cur[i];
            if (m_best[i] == 0 || m_cur[i] < m_best[i]) m_best[i] = m_cur[i];
            m_cnt[i]++;
            if (m_cnt[i] == LTW) begin m_done[i] = 1; m_run[i] = 0; end
          end
          m_cur[i] = 0;
          m_exc[i] = 0;
        end else if (tk) begin
          if (m_cur[i] < MAXT) m_cur[i]++;
          else m_exc[i] = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge pclk) begin
    for (int p = 0; p < NP; p++) begin
      check("current", p, cur_o[p*TW +: TW], m_cur[p]);
      check("last", p, last_o[p*TW +: TW], m_last[p]);
      check("best", p, best_o[p*TW +: TW], m_best[p]);
      check("lap_count", p, cnt_o[p*LCW +: LCW], m_cnt[p]);
      check("timeout", p, exc_o[p], m_exc[p]);
      check("finished", p, fin_o[p], m_done[p]);
    end
    check("winner_valid", 0, wv_o, m_wv);
    check("winner_id", 0, wid_o, m_wid);
    check("race_done", 0, rd_o, m_rd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cur(input int p, input int target);
    for (int k = 0; k < 200; k++) begin
      if (m_cur[p] == target) return;
      @(negedge pclk);
    end
    n_total++;
    $display("FAIL wait_cur[%0d] got %0d expected %0d (cycle budget spent)", p, m_cur[p], target);
  endtask

  task automatic wait_timeout(input int p);
    for (int k = 0; k < 200; k++) begin
      if (m_exc[p]) return;
      @(negedge pclk);
    end
    n_total++;
    $display("FAIL wait_timeout[%0d] got 0 expected 1 (cycle budget spent)", p);
  endtask

  task automatic pulse_lap(input logic [NP-1:0] which);
    lap = which;
    @(negedge pclk);
    lap = '0;
  endtask

  int hold0, hold1;

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; stop = 0; clear = 0; lap = '0; cp = '0;
    repeat (2) @(negedge pclk);
    rst = 0;
    // reset state
    check("pin_rst_cur", 0, cur_o, 0);
    check("pin_rst_cnt", 0, cnt_o, 0);
    check("pin_rst_best", 0, best_o, 0);
    check("pin_rst_win", 0, {wv_o, rd_o, fin_o, exc_o}, 0);

    // start then 20 cycles: 5 ticks of 4 cycles each
    start = 1; @(negedge pclk); start = 0;
    repeat (20) @(negedge pclk);
    check("pin_cur5", 0, cur_o[0 +: TW], 5);
    check("pin_cur5", 1, cur_o[TW +: TW], 5);
    check("pin_cnt0", 0, cnt_o, 0);

    // valid lap at 10
    cp[0] = 1;
    wait_cur(0, 10); pulse_lap(2'b01);
    check("pin_last10", 0, last_o[0 +: TW], 10);
    check("pin_best10", 0, best_o[0 +: TW], 10);
    check("pin_cnt1", 0, cnt_o[0 +: LCW], 1);
    check("pin_cur_zero", 0, cur_o[0 +: TW], 0);

    // boundary: exactly MIN_LAP_TIME is not valid
    wait_cur(0, 3); pulse_lap(2'b01);
    check("pin_min_cnt", 0, cnt_o[0 +: LCW], 1);
    check("pin_min_last", 0, last_o[0 +: TW], 10);
    check("pin_min_cur", 0, cur_o[0 +: TW], 0);

    // missing checkpoints
    cp[0] = 0;
    wait_cur(0, 10); pulse_lap(2'b01);
    check("pin_cp_cnt", 0, cnt_o[0 +: LCW], 1);
    check("pin_cp_best", 0, best_o[0 +: TW], 10);

    // P1 has been running since start: saturates and times out
    wait_timeout(1);
    check("pin_sat_cur", 1, cur_o[TW +: TW], 20);
    check("pin_sat_flag", 1, exc_o[1], 1);
    cp[1] = 1;
    pulse_lap(2'b10);
    check("pin_to_cnt", 1, cnt_o[LCW +: LCW], 0);
    check("pin_to_flag", 1, exc_o[1], 0);
    check("pin_to_cur", 1, cur_o[TW +: TW], 0);

    // pause with a dropped lap pulse, then resume
    repeat (6) @(negedge pclk);
    hold0 = m_cur[0]; hold1 = m_cur[1];
    cp[0] = 1;
    stop = 1;
    repeat (4) @(negedge pclk);
    pulse_lap(2'b11);
    repeat (5) @(negedge pclk);
    check("pin_pause_cur", 0, cur_o[0 +: TW], hold0);
    check("pin_pause_cur", 1, cur_o[TW +: TW], hold1);
    check("pin_pause_cnt", 0, cnt_o[0 +: LCW], 1);
    stop = 0; start = 1; @(negedge pclk); start = 0;

    // P0 final lap at 7: new best, finish, winner
    cp[0] = 0; pulse_lap(2'b01);
    cp[0] = 1;
    wait_cur(0, 7); pulse_lap(2'b01);
    check("pin_best7", 0, best_o[0 +: TW], 7);
    check("pin_cnt2", 0, cnt_o[0 +: LCW], 2);
    check("pin_fin0", 0, fin_o[0], 1);
    @(negedge pclk);
    check("pin_wv", 0, wv_o, 1);
    check("pin_wid", 0, wid_o, 0);
    check("pin_rd_no", 0, rd_o, 0);

    // FINISHED ignores stop/start/lap
    stop = 1; @(negedge pclk); stop = 0;
    start = 1; @(negedge pclk); start = 0;
    pulse_lap(2'b01);
    repeat (8) @(negedge pclk);
    check("pin_frozen_cur", 0, cur_o[0 +: TW], 0);
    check("pin_frozen_cnt", 0, cnt_o[0 +: LCW], 2);

    // clear
    clear = 1; @(negedge pclk); clear = 0;
    check("pin_clr_cnt", 0, cnt_o, 0);
    check("pin_clr_best", 0, best_o, 0);
    check("pin_clr_wv", 0, wv_o, 0);

    // simultaneous finish
    cp = 2'b11;
    start = 1; @(negedge pclk); start = 0;
    wait_cur(0, 5); pulse_lap(2'b11);
    check("pin_sim_cnt", 0, cnt_o, 8'h11);
    wait_cur(0, 5); pulse_lap(2'b11);
    check("pin_sim_fin", 0, fin_o, 3);
    check("pin_sim_rd0", 0, rd_o, 0);
    @(negedge pclk);
    check("pin_sim_wv", 0, wv_o, 1);
    check("pin_sim_wid", 0, wid_o, 0);
    check("pin_sim_rd", 0, rd_o, 1);

    repeat (3) @(negedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/race_timer.md
Name: race_timer

Overview:
- Multi-player successor to the single-car lap timer: one shared 0.01 s tick prescaler drives NUM_PLAYERS independent lap-timing channels.
- Per channel: current, last and best lap time, valid-lap count, timeout flag.
- Detects the race winner (first to LAPS_TO_WIN valid laps) and race completion.
- Sits between track/checkpoint logic and the HUD/scoreboard renderer.

Parameters:
- NUM_PLAYERS, 2, number of independent timing channels (1..8).
- TICK_DIV, 650000, pclk cycles per 0.01 s time unit (≥2).
- TIME_W, 16, width of every lap-time value.
- MAX_LAP_TIME, 4000, saturation limit in time units.
- MIN_LAP_TIME, 100, a lap must be strictly greater than this to be valid.
- LAPS_TO_WIN, 3, number of valid laps that finishes a player.
- LAP_CNT_W, 4, width of each lap counter (must hold LAPS_TO_WIN).
- ID_W, 3, width of the winner index.

Ports:
- pclk in 1 pixel/system clock.
- rst in 1 synchronous, active-high reset.
- start in 1 level; resume/start counting.
- stop in 1 level; pause all channels.
- clear in 1 pulse; zero all statistics and start a new race.
- lap_finished in NUM_PLAYERS per-player finish-line pulse.
- checkpoints_passed in NUM_PLAYERS per-player "all checkpoints seen" level.
- current_lap_time out NUM_PLAYERS*TIME_W packed, player 0 in LSBs.
- last_lap_time out NUM_PLAYERS*TIME_W last valid lap.
- best_lap_time out NUM_PLAYERS*TIME_W best valid lap; 0 means none yet.
- lap_count out NUM_PLAYERS*LAP_CNT_W valid laps completed.
- max_time_exceeded out NUM_PLAYERS per-player timeout flag.
- player_finished out NUM_PLAYERS player reached LAPS_TO_WIN.
- winner_valid out 1 a winner has been decided.
- winner_id out ID_W index of the winner.
- race_done out 1 all players finished.

Behaviour:
- Reset (rst, or clear outside reset): all outputs 0; every channel goes to IDLE; prescaler goes to 0. clear has the same effect as rst, one cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while at least one channel is in COUNT.
  - Emits a one-cycle tick on the wrap.
  - Holds its value while no channel is counting (pause preserves sub-unit phase).
- Per-channel FSM states are IDLE, COUNT and FINISHED.
  - IDLE → COUNT when start=1 and stop=0.
  - COUNT → IDLE when stop=1. stop has priority over start and over lap events in the same cycle; that lap event is dropped.
  - COUNT → FINISHED when a valid lap makes lap_count equal LAPS_TO_WIN.
  - FINISHED is left only via rst or clear. stop and start are ignored there, and all values are frozen.
- In COUNT, on tick:
  - If current < MAX_LAP_TIME, current increments by 1.
  - Otherwise current saturates at MAX_LAP_TIME and max_time_exceeded is set to 1. Current does not wrap.
- In COUNT, on lap_finished[i], registered the next cycle with no dead cycle:
  - valid = checkpoints_passed[i] && !max_time_exceeded[i] && current > MIN_LAP_TIME.
  - If valid: last ← current; best ← current if best==0 or current<best; lap_count increments.
  - Always: current ← 0 and max_time_exceeded ← 0.
  - A tick in the same cycle is discarded for that channel; current becomes 0, not 1.
- lap_finished outside COUNT is ignored.
- Winner:
  - The first cycle any player_finished bit rises with winner_valid=0 sets winner_valid=1 and winner_id to the lowest finishing index.
  - winner_valid and winner_id are sticky until rst or clear.
- race_done = AND of player_finished, registered.
- Latency: every output updates one pclk after its causing input or tick.
- Comparisons are unsigned at TIME_W width; lap_count never exceeds LAPS_TO_WIN.

Decomposition:
- Package race_timer_pkg holds:
  - the channel state encoding (IDLE, COUNT, FINISHED) as a 2-bit typedef;
  - the default time constants (TICK_DIV, MAX_LAP_TIME, MIN_LAP_TIME);
  - a function for the valid-lap check.
- Sub-module lap_timer_channel is one per player, generated NUM_PLAYERS times. It contains the FSM, current/last/best/lap_count and the timeout flag.
- Top level race_timer keeps the prescaler, the winner arbitration and race_done.

Test Plan:
- All tests use TICK_DIV=4, MIN_LAP_TIME=3, MAX_LAP_TIME=20, LAPS_TO_WIN=2, NUM_PLAYERS=2.
- Reset: rst 1 cycle → all outputs 0. start, then 20 cycles → current_lap_time of both players = 5; lap_count = 0.
- Valid lap: P0 with checkpoints=1 and current=10, pulse lap_finished[0] → last=10, best=10, lap_count=1, current=0. Next lap at current=7 → best=7, player_finished[0]=1, winner_valid=1, winner_id=0.
- Invalid lap:
  - current=3 with checkpoints=1 → last/best/lap_count unchanged, current=0.
  - current=10 with checkpoints=0 → same.
- Timeout: run P1 for 25 ticks → current saturates at 20 and max_time_exceeded[1]=1. Then lap_finished[1] → not counted, flag cleared, current=0.
- Simultaneous finish: both players on their last valid lap in the same cycle → winner_id=0, race_done=1 one cycle later.
- Pause and clear:
  - stop for 10 cycles while a lap_finished pulse arrives → times frozen, lap ignored. start resumes from the held value.
  - clear pulse → all statistics 0, winner_valid=0.
